ddr_frame_sched: RTL and testbench

//  Schedules whole-frame transfers between the USB host and DDR through the dual-port memc/USB interface.

---
 rtl/ddr_sched_pkg.sv | 28 ++
 rtl/xfer_word_ctr.sv | 33 +++
 rtl/ddr_frame_sched.sv | 209 ++++++++++++++++++++
 tb/tb_ddr_frame_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : ddr_sched_pkg
// Desc    : Shared types and constants for the DDR frame scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SETUP = 3'd1,
    ST_WR       = 3'd2,
    ST_WR_DRAIN = 3'd3,
    ST_RD_SETUP = 3'd4,
    ST_RD       = 3'd5
  } sched_state_e;

  localparam logic c_grant_wr = 1'b0;
  localparam logic c_grant_rd = 1'b1;

  localparam int unsigned c_bytes_per_word = 4;

  function automatic logic [29:0] frame_bytes(input int unsigned words);
    return 30'(words * c_bytes_per_word);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xfer_word_ctr.sv
`default_nettype none
// ============================================================================
// Module : xfer_word_ctr
// Desc   : Word counter with clear and saturating terminal-count compare.
// Rev    : 1.0  initial release
// ============================================================================
module xfer_word_ctr #(
  parameter int unsigned MAX_COUNT = 8,
  parameter int unsigned CNT_W     = $clog2(MAX_COUNT) + 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] r_count;

  assign tc_o = (r_count == CNT_W'(MAX_COUNT));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (inc_i && !tc_o) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module : ddr_frame_sched
// Desc   : Serialised whole-frame write/read scheduler over a DDR ping-pong pair.
// Rev    : 1.0  initial release
// ============================================================================
module ddr_frame_sched
  import ddr_sched_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 65536,
  parameter logic [29:0] BUF0_BASE   = 30'h0000000,
  parameter logic [29:0] BUF1_BASE   = 30'h0100000,
  parameter int unsigned DRAIN_CYC   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        calib_done_i,
  input  logic        wr_req_i,
  input  logic        rd_req_i,
  input  logic        abort_i,
  input  logic        usb2mem_en_p0_i,
  input  logic        empty_inFIFO_p0_i,
  input  logic        mem2usb_en_p1_i,
  output logic [29:0] start_wr_addr_o,
  output logic [29:0] end_wr_addr_o,
  output logic [29:0] start_rd_addr_o,
  output logic [29:0] rd_len_o,
  output logic        new_wraddr_req_p0_o,
  output logic        data_wr_req_p0_o,
  output logic        data_rd_req_p1_o,
  output logic        busy_o,
  output logic        wr_done_o,
  output logic        rd_done_o,
  output logic        rd_err_o,
  output logic        ovf_err_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned c_cnt_w   = $clog2(FRAME_WORDS) + 1;
  localparam int unsigned c_drain_w = $clog2(DRAIN_CYC + 1);
  localparam logic [29:0] c_frame_bytes = frame_bytes(FRAME_WORDS);
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(DRAIN_CYC - 1);

  sched_state_e r_state, w_state_nxt;

  logic                 r_wr_pend, r_rd_pend, r_last_grant;
  logic                 r_wr_buf, r_newest;
  logic [1:0]           r_buf_valid;
  logic [c_drain_w-1:0] r_drain_cnt;

  logic w_grant_wr, w_grant_rd, w_rd_err;
  logic w_wr_fin, w_rd_fin, w_abort_wr, w_abort_rd;
  logic w_new_wraddr, w_data_wr, w_data_rd;
  logic w_abort, w_drain_ok, w_word_tc, w_ctr_clr, w_ctr_inc, w_rd_buf;
  logic [29:0] w_wr_base, w_rd_base;

  assign w_abort    = abort_i || !calib_done_i;
  assign w_drain_ok = empty_inFIFO_p0_i && (r_drain_cnt == c_drain_last);
  // Oldest valid buffer is only read when the newest has already been consumed.
  assign w_rd_buf   = r_buf_valid[r_newest] ? r_newest : ~r_newest;
  assign w_wr_base  = r_wr_buf ? BUF1_BASE : BUF0_BASE;
  assign w_rd_base  = w_rd_buf ? BUF1_BASE : BUF0_BASE;
  assign w_ctr_clr  = (r_state == ST_WR_SETUP) || (r_state == ST_RD_SETUP);
  assign w_ctr_inc  = ((r_state == ST_WR) && usb2mem_en_p0_i) ||
                      ((r_state == ST_RD) && mem2usb_en_p1_i);

  xfer_word_ctr #(
    .MAX_COUNT (FRAME_WORDS),
    .CNT_W     (c_cnt_w)
  ) u_word_ctr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (w_ctr_clr),
    .inc_i   (w_ctr_inc),
    .tc_o    (w_word_tc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_wr   = 1'b0;
    w_grant_rd   = 1'b0;
    w_rd_err     = 1'b0;
    w_wr_fin     = 1'b0;
    w_rd_fin     = 1'b0;
    w_abort_wr   = 1'b0;
    w_abort_rd   = 1'b0;
    w_new_wraddr = 1'b0;
    w_data_wr    = 1'b0;
    w_data_rd    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (calib_done_i) begin
          if (r_wr_pend && (!r_rd_pend || r_last_grant == c_grant_rd)) begin
            w_grant_wr  = 1'b1;
            w_state_nxt = ST_WR_SETUP;
          end else if (r_rd_pend) begin
            w_grant_rd = 1'b1;
            if (r_buf_valid == 2'b00) w_rd_err = 1'b1;
            else                      w_state_nxt = ST_RD_SETUP;
          end
        end
      end
      ST_WR_SETUP: begin
        w_new_wraddr = 1'b1;
        w_state_nxt  = ST_WR;
      end
      ST_WR: begin
        w_data_wr = 1'b1;
        if (w_abort) begin
          w_abort_wr  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_word_tc) begin
          w_state_nxt = ST_WR_DRAIN;
        end
      end
      ST_WR_DRAIN: begin
        w_data_wr = 1'b1;
        if (w_abort) begin
          w_abort_wr  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_drain_ok) begin
          w_wr_fin    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_SETUP: begin
        w_state_nxt = ST_RD;
      end
      ST_RD: begin
        w_data_rd = 1'b1;
        if (w_abort) begin
          w_abort_rd  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_word_tc) begin
          w_rd_fin    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wr_pend       <= 1'b0;
      r_rd_pend       <= 1'b0;
      r_last_grant    <= c_grant_rd;
      r_wr_buf        <= 1'b0;
      r_newest        <= 1'b0;
      r_buf_valid     <= 2'b00;
      r_drain_cnt     <= '0;
      start_wr_addr_o <= '0;
      end_wr_addr_o   <= '0;
      start_rd_addr_o <= '0;
      rd_len_o        <= '0;
      wr_done_o       <= 1'b0;
      rd_done_o       <= 1'b0;
      ovf_err_o       <= 1'b0;
      frame_cnt_o     <= '0;
    end else begin
      // Clearing on grant or abort wins over a request arriving in the same cycle.
      r_wr_pend <= (r_wr_pend | wr_req_i) & ~(w_grant_wr | w_abort_wr);
      r_rd_pend <= (r_rd_pend | rd_req_i) & ~(w_grant_rd | w_abort_rd);
      wr_done_o <= w_wr_fin;
      rd_done_o <= w_rd_fin;

      if (w_grant_wr) begin
        r_last_grant            <= c_grant_wr;
        start_wr_addr_o         <= w_wr_base;
        end_wr_addr_o           <= w_wr_base + c_frame_bytes - 30'd8;
        r_buf_valid[r_wr_buf]   <= 1'b0;
      end
      if (w_grant_rd) begin
        r_last_grant <= c_grant_rd;
        if (!w_rd_err) begin
          start_rd_addr_o       <= w_rd_base;
          rd_len_o              <= c_frame_bytes;
          r_buf_valid[w_rd_buf] <= 1'b0;
        end
      end
      if (w_wr_fin) begin
        r_buf_valid[r_wr_buf] <= 1'b1;
        r_newest              <= r_wr_buf;
        r_wr_buf              <= ~r_wr_buf;
        frame_cnt_o           <= frame_cnt_o + 16'd1;
      end

      if ((r_state == ST_WR) && w_word_tc && usb2mem_en_p0_i) ovf_err_o <= 1'b1;

      if ((r_state == ST_WR_DRAIN) && empty_inFIFO_p0_i && !w_drain_ok)
        r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
      else
        r_drain_cnt <= '0;
    end
  end

  assign new_wraddr_req_p0_o = w_new_wraddr;
  assign data_wr_req_p0_o    = w_data_wr;
  assign data_rd_req_p1_o    = w_data_rd;
  assign rd_err_o            = w_rd_err;
  assign busy_o              = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr_frame_sched
// Desc   : Self-checking bench for ddr_frame_sched (8-word frames).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ddr_frame_sched;

  localparam int          c_fw    = 8;
  localparam int          c_drain = 16;
  localparam logic [29:0] c_b0    = 30'h0000000;
  localparam logic [29:0] c_b1    = 30'h0100000;

  logic        clk, rst_n_i, calib_done_i, wr_req_i, rd_req_i, abort_i;
  logic        usb2mem_en_p0_i, empty_inFIFO_p0_i, mem2usb_en_p1_i;
  logic [29:0] start_wr_addr_o, end_wr_addr_o, start_rd_addr_o, rd_len_o;
  logic        new_wraddr_req_p0_o, data_wr_req_p0_o, data_rd_req_p1_o, busy_o;
  logic        wr_done_o, rd_done_o, rd_err_o, ovf_err_o;
  logic [15:0] frame_cnt_o;
  logic        any_out;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_frame_sched #(
    .FRAME_WORDS (c_fw),
    .BUF0_BASE   (c_b0),
    .BUF1_BASE   (c_b1),
    .DRAIN_CYC   (c_drain)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n_i),
    .calib_done_i        (calib_done_i),
    .wr_req_i            (wr_req_i),
    .rd_req_i            (rd_req_i),
    .abort_i             (abort_i),
    .usb2mem_en_p0_i     (usb2mem_en_p0_i),
    .empty_inFIFO_p0_i   (empty_inFIFO_p0_i),
    .mem2usb_en_p1_i     (mem2usb_en_p1_i),
    .start_wr_addr_o     (start_wr_addr_o),
    .end_wr_addr_o       (end_wr_addr_o),
    .start_rd_addr_o     (start_rd_addr_o),
    .rd_len_o            (rd_len_o),
    .new_wraddr_req_p0_o (new_wraddr_req_p0_o),
    .data_wr_req_p0_o    (data_wr_req_p0_o),
    .data_rd_req_p1_o    (data_rd_req_p1_o),
    .busy_o              (busy_o),
    .wr_done_o           (wr_done_o),
    .rd_done_o           (rd_done_o),
    .rd_err_o            (rd_err_o),
    .ovf_err_o           (ovf_err_o),
    .frame_cnt_o         (frame_cnt_o)
  );

  assign any_out = |{start_wr_addr_o, end_wr_addr_o, start_rd_addr_o, rd_len_o,
                     new_wraddr_req_p0_o, data_wr_req_p0_o, data_rd_req_p1_o, busy_o,
                     wr_done_o, rd_done_o, rd_err_o, ovf_err_o, frame_cnt_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got time limit reached, required run completion");
    $fatal(1, "bench time limit");
  end

  // Reference model of the ping-pong pair: validity plus completion age per buffer.
  bit          m_valid [2];
  int          m_age   [2];
  int          m_gen;
  int          m_wrbuf;
  logic [15:0] m_fc;

  function automatic logic [29:0] base_of(input int b);
    return (b != 0) ? c_b1 : c_b0;
  endfunction

  task automatic model_reset();
    m_valid[0] = 0; m_valid[1] = 0;
    m_age[0] = 0; m_age[1] = 0;
    m_gen = 0; m_wrbuf = 0; m_fc = 16'd0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0; wr_req_i = 1'b0; rd_req_i = 1'b0; abort_i = 1'b0;
    usb2mem_en_p0_i = 1'b0; mem2usb_en_p1_i = 1'b0; calib_done_i = 1'b1;
    empty_inFIFO_p0_i = 1'b1;
    step(); step();
    check("reset_outs", any_out, 0);
    rst_n_i = 1'b1;
    step();
    model_reset();
  endtask

  task automatic do_abort(input bit use_calib);
    if (use_calib) calib_done_i = 1'b0;
    else           abort_i = 1'b1;
    usb2mem_en_p0_i = 1'b0; mem2usb_en_p1_i = 1'b0;
    step();
    abort_i = 1'b0; calib_done_i = 1'b1;
    check("abort_idle", busy_o, 0);
    check("abort_req_levels", data_wr_req_p0_o | data_rd_req_p1_o, 0);
    check("abort_no_done", wr_done_o | rd_done_o, 0);
    step();
    check("abort_stays_idle", busy_o | wr_done_o | rd_done_o, 0);
  endtask

  // Full write transaction; abort_at<0 completes, glitch_at>=0 drops empty once in drain.
  task automatic do_write(input bit send_req, input int abort_at, input bit use_calib,
                          input int glitch_at, input logic [29:0] exp_start,
                          input logic [15:0] exp_fc);
    int lat, issued, n, done_at, exp_steps;
    lat = 0; issued = 0; n = 0; done_at = -1;
    if (send_req) wr_req_i = 1'b1;
    do begin
      step(); wr_req_i = 1'b0; rd_req_i = 1'b0; lat++;
    end while (!new_wraddr_req_p0_o && lat < 60);
    check("wr_setup_seen", new_wraddr_req_p0_o, 1);
    if (send_req) check("wr_latency", lat, 2);
    check("wr_start_addr", start_wr_addr_o, exp_start);
    check("wr_end_addr", end_wr_addr_o, exp_start + 30'(c_fw * 4) - 30'd8);
    empty_inFIFO_p0_i = 1'b0;
    step();
    check("wr_addr_pulse_1cyc", new_wraddr_req_p0_o, 0);
    check("wr_req_level", data_wr_req_p0_o, 1);
    while (issued < c_fw && n < 200) begin
      if (abort_at >= 0 && issued == abort_at) begin
        do_abort(use_calib);
        empty_inFIFO_p0_i = 1'b1;
        check("wr_abort_frame_cnt", frame_cnt_o, exp_fc);
        return;
      end
      usb2mem_en_p0_i = ($urandom_range(0, 3) != 0);
      if (usb2mem_en_p0_i) issued++;
      step(); n++;
    end
    usb2mem_en_p0_i = 1'b0;
    step();
    exp_steps = (glitch_at >= 0) ? glitch_at + 1 + c_drain : c_drain;
    n = 0;
    while (done_at < 0 && n < exp_steps + 8) begin
      empty_inFIFO_p0_i = (n != glitch_at);
      step(); n++;
      if (wr_done_o) done_at = n;
    end
    empty_inFIFO_p0_i = 1'b1;
    check("wr_done_cycle", done_at, exp_steps);
    check("wr_req_drop", data_wr_req_p0_o, 0);
    check("frame_cnt", frame_cnt_o, exp_fc);
    step();
    check("wr_done_1cyc", wr_done_o, 0);
  endtask

  task automatic do_read(input bit send_req, input bit exp_err, input logic [29:0] exp_start,
                         input int abort_at, input bit use_calib);
    int lat, issued, n;
    lat = 0; issued = 0; n = 0;
    if (send_req) rd_req_i = 1'b1;
    do begin
      step(); rd_req_i = 1'b0; wr_req_i = 1'b0; lat++;
    end while (!(rd_err_o || data_rd_req_p1_o) && lat < 60);
    if (exp_err) begin
      check("rd_err", rd_err_o, 1);
      if (send_req) check("rd_err_latency", lat, 1);
      check("rd_err_no_req", data_rd_req_p1_o, 0);
      step();
      check("rd_err_1cyc", rd_err_o | busy_o | data_rd_req_p1_o, 0);
      return;
    end
    check("rd_req_level", data_rd_req_p1_o, 1);
    check("rd_no_err", rd_err_o, 0);
    check("rd_start_addr", start_rd_addr_o, exp_start);
    check("rd_len", rd_len_o, 30'(c_fw * 4));
    while (issued < c_fw && n < 200) begin
      if (abort_at >= 0 && issued == abort_at) begin
        do_abort(use_calib);
        return;
      end
      mem2usb_en_p1_i = ($urandom_range(0, 2) != 0);
      if (mem2usb_en_p1_i) issued++;
      step(); n++;
    end
    mem2usb_en_p1_i = 1'b0;
    n = 0;
    while (!rd_done_o && n < 6) begin step(); n++; end
    check("rd_done", rd_done_o, 1);
    check("rd_done_latency", n, 1);
    check("rd_req_drop", data_rd_req_p1_o, 0);
    step();
    check("rd_done_1cyc", rd_done_o, 0);
  endtask

  typedef struct {
    bit          is_rd;
    bit          exp_err;
    logic [29:0] exp_addr;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int  op, b, ab_at;
    bit  use_cal, hold_bad;
    int  n;

    tbl[0] = '{1, 1, c_b0, 16'd0};
    tbl[1] = '{0, 0, c_b0, 16'd1};
    tbl[2] = '{0, 0, c_b1, 16'd2};
    tbl[3] = '{1, 0, c_b1, 16'd0};
    tbl[4] = '{1, 0, c_b0, 16'd0};
    tbl[5] = '{1, 1, c_b0, 16'd0};
    tbl[6] = '{0, 0, c_b0, 16'd3};
    tbl[7] = '{0, 0, c_b1, 16'd4};
    tbl[8] = '{1, 0, c_b1, 16'd0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].is_rd) do_read(1, tbl[i].exp_err, tbl[i].exp_addr, -1, 0);
      else              do_write(1, -1, 0, (i == 2) ? 9 : -1, tbl[i].exp_addr, tbl[i].exp_fc);
    end

    // Simultaneous requests after a read grant: write first, queued read follows.
    rd_req_i = 1'b1;
    do_write(1, -1, 0, -1, c_b0, 16'd5);
    do_read(0, 0, c_b0, -1, 0);

    // Overflow and abort.
    do_reset();
    wr_req_i = 1'b1; step(); wr_req_i = 1'b0; step();
    check("ovf_setup", new_wraddr_req_p0_o, 1);
    step();
    usb2mem_en_p0_i = 1'b1;
    repeat (c_fw) step();
    check("ovf_at_frame", ovf_err_o, 0);
    step();
    usb2mem_en_p0_i = 1'b0;
    check("ovf_set", ovf_err_o, 1);
    check("ovf_drain_req", data_wr_req_p0_o, 1);
    do_abort(0);
    check("ovf_abort_fc", frame_cnt_o, 0);
    check("ovf_sticky", ovf_err_o, 1);
    do_read(1, 1, c_b0, -1, 0);
    do_write(1, 3, 0, -1, c_b0, 16'd0);
    do_read(1, 1, c_b0, -1, 0);
    check("ovf_still_sticky", ovf_err_o, 1);

    // Reset mid-read, then requests pending while calibration is low.
    do_reset();
    do_write(1, -1, 0, -1, c_b0, 16'd1);
    rd_req_i = 1'b1; step(); rd_req_i = 1'b0;
    n = 0;
    while (!data_rd_req_p1_o && n < 10) begin step(); n++; end
    check("t6_rd_active", data_rd_req_p1_o, 1);
    mem2usb_en_p1_i = 1'b1; repeat (3) step(); mem2usb_en_p1_i = 1'b0;
    rst_n_i = 1'b0;
    step();
    check("t6_rd_req_drop", data_rd_req_p1_o, 0);
    check("t6_all_zero", any_out, 0);
    rst_n_i = 1'b1; calib_done_i = 1'b0;
    model_reset();
    wr_req_i = 1'b1; rd_req_i = 1'b1; step(); wr_req_i = 1'b0; rd_req_i = 1'b0;
    hold_bad = 1'b0;
    repeat (6) begin
      step();
      hold_bad = hold_bad | busy_o | new_wraddr_req_p0_o | rd_err_o | rd_done_o;
    end
    check("t6_calib_hold", hold_bad, 0);
    calib_done_i = 1'b1;
    do_write(0, -1, 0, -1, c_b0, 16'd1);
    do_read(0, 0, c_b0, -1, 0);

    // Randomised operations against the buffer model.
    do_reset();
    repeat (40) begin
      op      = $urandom_range(0, 9);
      ab_at   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, c_fw - 1) : -1;
      use_cal = $urandom_range(0, 1);
      if (op < 5) begin
        b = m_wrbuf;
        m_valid[b] = 0;
        if (ab_at < 0) begin
          m_valid[b] = 1; m_gen++; m_age[b] = m_gen;
          m_wrbuf = 1 - m_wrbuf; m_fc = m_fc + 16'd1;
        end
        do_write(1, ab_at, use_cal,
                 ($urandom_range(0, 1) != 0) ? $urandom_range(0, c_drain - 1) : -1,
                 base_of(b), m_fc);
      end else if (!m_valid[0] && !m_valid[1]) begin
        do_read(1, 1, c_b0, -1, 0);
      end else begin
        if (m_valid[0] && m_valid[1]) b = (m_age[1] > m_age[0]) ? 1 : 0;
        else                          b = m_valid[1] ? 1 : 0;
        m_valid[b] = 0;
        do_read(1, 0, base_of(b), ab_at, use_cal);
      end
    end
    check("rand_no_ovf", ovf_err_o, 0);
    check("rand_frame_cnt", frame_cnt_o, m_fc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
